// File: rtl/mdr_control_unit.sv
// Sequencer for the multiply/divide/square-root datapath: latches a request, screens it,
// launches one unit, waits for its done (or a timeout) and registers the mux result.
module mdr_control_unit #(
    parameter int NBits          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op_code,
    input  logic [NBits-1:0] data_x,
    input  logic [NBits-1:0] data_y,
    output logic [NBits-1:0] operand_x,
    output logic [NBits-1:0] operand_y,
    output logic             start_mult,
    output logic             start_div,
    output logic             start_sqr,
    input  logic             done_mult,
    input  logic             done_div,
    input  logic             done_sqr,
    output logic [1:0]       mux_selector,
    input  logic [NBits-1:0] mux_result,
    output logic [NBits-1:0] result,
    output logic             result_valid,
    output logic             error,
    output logic             busy
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CHECK, LAUNCH, WAIT} state_t;

    state_t           state_q, state_d;
    logic [NBits-1:0] operand_x_q, operand_x_d;
    logic [NBits-1:0] operand_y_q, operand_y_d;
    logic [1:0]       sel_q, sel_d;
    logic [NBits-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             busy_q, busy_d;
    logic             start_mult_q, start_mult_d;
    logic             start_div_q, start_div_d;
    logic             start_sqr_q, start_sqr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bad_req;
    logic             done_sel;

    // The selector register doubles as the latched opcode.
    always_comb begin
        bad_req = (sel_q == 2'b11)
                || (sel_q == 2'b01 && operand_y_q == '0)
                || (sel_q == 2'b10 && operand_x_q[NBits-1]);
        case (sel_q)
            2'b00:   done_sel = done_mult;
            2'b01:   done_sel = done_div;
            2'b10:   done_sel = done_sqr;
            default: done_sel = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        operand_x_d  = operand_x_q;
        operand_y_d  = operand_y_q;
        sel_d        = sel_q;
        result_d     = result_q;
        error_d      = error_q;
        cnt_d        = cnt_q;
        valid_d      = 1'b0;
        start_mult_d = 1'b0;
        start_div_d  = 1'b0;
        start_sqr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    operand_x_d = data_x;
                    operand_y_d = data_y;
                    sel_d       = op_code;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (bad_req) begin
                    result_d = '0;
                    error_d  = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    // Pulse is registered here so it is high exactly during LAUNCH.
                    start_mult_d = (sel_q == 2'b00);
                    start_div_d  = (sel_q == 2'b01);
                    start_sqr_d  = (sel_q == 2'b10);
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_sel) begin
                    result_d = mux_result;
                    error_d  = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = '0;
                    error_d  = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            operand_x_q  <= '0;
            operand_y_q  <= '0;
            sel_q        <= '0;
            result_q     <= '0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            start_mult_q <= 1'b0;
            start_div_q  <= 1'b0;
            start_sqr_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            operand_x_q  <= operand_x_d;
            operand_y_q  <= operand_y_d;
            sel_q        <= sel_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            start_mult_q <= start_mult_d;
            start_div_q  <= start_div_d;
            start_sqr_q  <= start_sqr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign operand_x    = operand_x_q;
    assign operand_y    = operand_y_q;
    assign mux_selector = sel_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign error        = error_q;
    assign busy         = busy_q;
    assign start_mult   = start_mult_q;
    assign start_div    = start_div_q;
    assign start_sqr    = start_sqr_q;

endmodule

// File: tb/tb_mdr_control_unit.sv
// Directed bench for mdr_control_unit: one task per scenario, cycle-accurate expectations.
module tb_mdr_control_unit;

    localparam int NB = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [1:0]    op_code;
    logic [NB-1:0] data_x, data_y, mux_result;
    logic          done_mult, done_div, done_sqr;
    logic [NB-1:0] operand_x, operand_y, result;
    logic          start_mult, start_div, start_sqr;
    logic [1:0]    mux_selector;
    logic          result_valid, error, busy;

    int errors = 0;
    int checks = 0;

    mdr_control_unit #(.NBits(NB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .op_code(op_code),
        .data_x(data_x), .data_y(data_y), .operand_x(operand_x), .operand_y(operand_y),
        .start_mult(start_mult), .start_div(start_div), .start_sqr(start_sqr),
        .done_mult(done_mult), .done_div(done_div), .done_sqr(done_sqr),
        .mux_selector(mux_selector), .mux_result(mux_result), .result(result),
        .result_valid(result_valid), .error(error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request accepted at the edge inside; returns in cycle 1 (CHECK).
    task automatic launch(input logic [1:0] op, input logic [NB-1:0] x, input logic [NB-1:0] y);
        start = 1'b1; op_code = op; data_x = x; data_y = y;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (result !== 16'd0) begin errors++; $display("FAIL rst_result got=%0h exp=0", result); end
        checks++; if ({result_valid, error} !== 2'b00) begin errors++; $display("FAIL rst_valid_err got=%b exp=00", {result_valid, error}); end
        checks++; if (mux_selector !== 2'b00) begin errors++; $display("FAIL rst_sel got=%b exp=00", mux_selector); end
        checks++; if ({operand_x, operand_y} !== 32'd0) begin errors++; $display("FAIL rst_operands got=%h exp=0", {operand_x, operand_y}); end
        checks++; if ({start_mult, start_div, start_sqr} !== 3'b000) begin errors++; $display("FAIL rst_starts got=%b exp=000", {start_mult, start_div, start_sqr}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mult();
        launch(2'b00, 16'd7, 16'd6);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy got=%0b exp=1", busy); end
        checks++; if ({operand_x, operand_y} !== {16'd7, 16'd6}) begin errors++; $display("FAIL mult_operands got=%h exp=00070006", {operand_x, operand_y}); end
        checks++; if (mux_selector !== 2'b00) begin errors++; $display("FAIL mult_sel got=%b exp=00", mux_selector); end
        tick(); // cycle 2
        checks++; if ({start_mult, start_div, start_sqr} !== 3'b100) begin errors++; $display("FAIL mult_launch got=%b exp=100", {start_mult, start_div, start_sqr}); end
        tick(); // cycle 3
        checks++; if (start_mult !== 1'b0) begin errors++; $display("FAIL mult_pulse_len got=%0b exp=0", start_mult); end
        tick(); tick(); // cycle 5
        done_mult = 1'b1; mux_result = 16'd42;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mult_early_valid got=%0b exp=0", result_valid); end
        tick(); // cycle 6
        done_mult = 1'b0; mux_result = 16'd0;
        checks++; if ({result_valid, error, busy} !== 3'b100) begin errors++; $display("FAIL mult_done_flags got=%b exp=100", {result_valid, error, busy}); end
        checks++; if (result !== 16'd42) begin errors++; $display("FAIL mult_result got=%0d exp=42", result); end
        tick(); // cycle 7
        checks++; if ({result_valid, result} !== {1'b0, 16'd42}) begin errors++; $display("FAIL mult_hold got=%0b/%0d exp=0/42", result_valid, result); end
    endtask

    task automatic test_check_errors();
        logic [1:0]    ops [3] = '{2'b01, 2'b10, 2'b11};
        logic [NB-1:0] xs  [3] = '{16'd9, 16'h8000, 16'd1};
        logic [NB-1:0] ys  [3] = '{16'd0, 16'd5, 16'd1};
        for (int i = 0; i < 3; i++) begin
            launch(ops[i], xs[i], ys[i]);
            checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL chk%0d_c1_valid got=%0b exp=0", i, result_valid); end
            tick(); // cycle 2
            checks++; if ({result_valid, error, busy} !== 3'b110) begin errors++; $display("FAIL chk%0d_flags got=%b exp=110", i, {result_valid, error, busy}); end
            checks++; if (result !== 16'd0) begin errors++; $display("FAIL chk%0d_result got=%0h exp=0", i, result); end
            checks++; if ({start_mult, start_div, start_sqr} !== 3'b000) begin errors++; $display("FAIL chk%0d_starts got=%b exp=000", i, {start_mult, start_div, start_sqr}); end
            tick(); // cycle 3
            checks++; if ({result_valid, error} !== 2'b01) begin errors++; $display("FAIL chk%0d_hold got=%b exp=01", i, {result_valid, error}); end
        end
    endtask

    task automatic test_timeout();
        launch(2'b01, 16'd8, 16'd2);
        tick(); // cycle 2
        checks++; if ({start_mult, start_div, start_sqr} !== 3'b010) begin errors++; $display("FAIL to_launch got=%b exp=010", {start_mult, start_div, start_sqr}); end
        tick(); // cycle 3, first WAIT cycle
        done_mult = 1'b1; mux_result = 16'd99;
        tick(); tick(); tick(); // cycle 6, fourth WAIT cycle
        checks++; if ({result_valid, busy} !== 2'b01) begin errors++; $display("FAIL to_early got=%b exp=01", {result_valid, busy}); end
        tick(); // cycle 7
        done_mult = 1'b0; mux_result = 16'd0;
        checks++; if ({result_valid, error, busy} !== 3'b110) begin errors++; $display("FAIL to_flags got=%b exp=110", {result_valid, error, busy}); end
        checks++; if (result !== 16'd0) begin errors++; $display("FAIL to_result got=%0d exp=0", result); end
        tick();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL to_valid_len got=%0b exp=0", result_valid); end
    endtask

    task automatic test_busy_start_and_reset();
        launch(2'b00, 16'd3, 16'd5);
        tick(); tick(); // cycle 3, WAIT
        start = 1'b1; op_code = 2'b11; data_x = 16'd0; data_y = 16'd0;
        tick(); // cycle 4
        start = 1'b0;
        checks++; if ({mux_selector, operand_x} !== {2'b00, 16'd3}) begin errors++; $display("FAIL busy_start_latch got=%b/%0d exp=00/3", mux_selector, operand_x); end
        done_mult = 1'b1; mux_result = 16'd15;
        tick(); // cycle 5
        done_mult = 1'b0;
        checks++; if ({result_valid, error, result} !== {2'b10, 16'd15}) begin errors++; $display("FAIL busy_start_result got=%b/%0d exp=10/15", {result_valid, error}, result); end
        tick();
        checks++; if ({busy, result_valid} !== 2'b00) begin errors++; $display("FAIL busy_start_queued got=%b exp=00", {busy, result_valid}); end

        launch(2'b01, 16'd20, 16'd4);
        tick(); tick(); // cycle 3, WAIT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({busy, result_valid, error} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags got=%b exp=000", {busy, result_valid, error}); end
        checks++; if ({result, mux_selector} !== 18'd0) begin errors++; $display("FAIL rst_mid_outs got=%0d/%b exp=0/00", result, mux_selector); end
        done_div = 1'b1; mux_result = 16'd5;
        tick();
        done_div = 1'b0;
        checks++; if ({busy, result_valid, result} !== 18'd0) begin errors++; $display("FAIL rst_mid_discard got=%b/%0d exp=00/0", {busy, result_valid}, result); end
    endtask

    task automatic test_back_to_back();
        launch(2'b00, 16'd6, 16'd7);
        tick(); tick(); // cycle 3
        done_mult = 1'b1; mux_result = 16'd42;
        tick(); // cycle 4, minimum latency
        done_mult = 1'b0;
        checks++; if ({result_valid, result} !== {1'b1, 16'd42}) begin errors++; $display("FAIL b2b_first got=%0b/%0d exp=1/42", result_valid, result); end
        launch(2'b10, 16'd16, 16'd0);
        checks++; if ({result_valid, busy, mux_selector} !== 4'b0110) begin errors++; $display("FAIL b2b_accept got=%b exp=0110", {result_valid, busy, mux_selector}); end
        checks++; if (operand_x !== 16'd16) begin errors++; $display("FAIL b2b_operand got=%0d exp=16", operand_x); end
        tick(); // cycle 2
        checks++; if ({start_mult, start_div, start_sqr} !== 3'b001) begin errors++; $display("FAIL b2b_launch got=%b exp=001", {start_mult, start_div, start_sqr}); end
        tick(); // cycle 3
        done_sqr = 1'b1; mux_result = 16'd4;
        tick(); // cycle 4
        done_sqr = 1'b0;
        checks++; if ({result_valid, error, result} !== {2'b10, 16'd4}) begin errors++; $display("FAIL b2b_second got=%b/%0d exp=10/4", {result_valid, error}, result); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op_code = 2'b00; data_x = '0; data_y = '0;
        mux_result = '0; done_mult = 1'b0; done_div = 1'b0; done_sqr = 1'b0;
        test_reset();
        test_mult();
        test_check_errors();
        test_timeout();
        test_busy_start_and_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
